// File: rtl/button_event_scheduler_if.sv
// Event output handshake between the scheduler and its consumer.
interface button_event_scheduler_if #(
  parameter int unsigned IDXW = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [IDXW-1:0] evt_idx;
  logic            evt_kind;

  modport master (
    output evt_valid,
    output evt_idx,
    output evt_kind,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_idx,
    input  evt_kind,
    output evt_ready
  );
endinterface

// File: rtl/button_event_scheduler.sv
// Serializes per-button rise/fall pulses into a single valid/ready event stream.
// Each button has a 2-deep FIFO of edge kinds; buttons are served round-robin.
module button_event_scheduler #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N-1:0]                    rise,
  input  logic [N-1:0]                    fall,
  button_event_scheduler_if.master        evt,
  output logic [N-1:0]                    overrun,
  input  logic                            clear_overrun
);

  localparam logic [1:0] Q_EMPTY = 2'd0;
  localparam logic [1:0] Q_ONE   = 2'd1;
  localparam logic [1:0] Q_TWO   = 2'd2;

  // Per-button queue: occupancy state plus older (k0) and newer (k1) kinds.
  logic [N-1:0][1:0] q_state;
  logic [N-1:0][1:0] q_state_nxt;
  logic [N-1:0]      q_k0;
  logic [N-1:0]      q_k0_nxt;
  logic [N-1:0]      q_k1;
  logic [N-1:0]      q_k1_nxt;
  logic [N-1:0]      overrun_nxt;

  logic [IDXW-1:0]   ptr;
  logic [IDXW-1:0]   ptr_nxt;

  logic              valid_nxt;
  logic [IDXW-1:0]   idx_nxt;
  logic              kind_nxt;

  logic [N-1:0]      cand_c;
  logic [IDXW-1:0]   grant_c;
  logic              grant_vld_c;
  logic              load_c;

  // State register: queues, RR pointer, overrun flags and the output event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_state       <= '0;
      q_k0          <= '0;
      q_k1          <= '0;
      overrun       <= '0;
      ptr           <= '0;
      evt.evt_valid <= 1'b0;
      evt.evt_idx   <= '0;
      evt.evt_kind  <= 1'b0;
    end else begin
      q_state       <= q_state_nxt;
      q_k0          <= q_k0_nxt;
      q_k1          <= q_k1_nxt;
      overrun       <= overrun_nxt;
      ptr           <= ptr_nxt;
      evt.evt_valid <= valid_nxt;
      evt.evt_idx   <= idx_nxt;
      evt.evt_kind  <= kind_nxt;
    end
  end

  // Buttons with a non-empty queue compete for the output.
  always_comb begin
    cand_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand_c[i] = (q_state[i] != Q_EMPTY);
    end
  end

  // Round-robin pick: first candidate at or above ptr, else lowest (wrap).
  always_comb begin
    grant_c     = '0;
    grant_vld_c = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!grant_vld_c && cand_c[i] && (32'(ptr) <= i)) begin
        grant_vld_c = 1'b1;
        grant_c     = IDXW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!grant_vld_c && cand_c[i]) begin
        grant_vld_c = 1'b1;
        grant_c     = IDXW'(i);
      end
    end
  end

  // Output register may only take a new event when empty or being consumed.
  always_comb begin
    load_c = (!evt.evt_valid || evt.evt_ready) && grant_vld_c;
  end

  // Queue update: pop the granted entry first, then apply this cycle's edge.
  always_comb begin
    q_state_nxt = q_state;
    q_k0_nxt    = q_k0;
    q_k1_nxt    = q_k1;
    overrun_nxt = clear_overrun ? '0 : overrun;
    for (int unsigned i = 0; i < N; i++) begin
      if (load_c && (grant_c == IDXW'(i))) begin
        q_k0_nxt[i]    = q_k1[i];
        q_state_nxt[i] = (q_state[i] == Q_TWO) ? Q_ONE : Q_EMPTY;
      end
      if (rise[i] && fall[i]) begin
        overrun_nxt[i] = 1'b1;
      end else if (rise[i] || fall[i]) begin
        case (q_state_nxt[i])
          Q_EMPTY: begin
            q_state_nxt[i] = Q_ONE;
            q_k0_nxt[i]    = rise[i];
          end
          Q_ONE: begin
            q_state_nxt[i] = Q_TWO;
            q_k1_nxt[i]    = rise[i];
          end
          default: overrun_nxt[i] = 1'b1;
        endcase
      end
    end
  end

  // Output event and RR pointer next state; held stable under backpressure.
  always_comb begin
    valid_nxt = evt.evt_valid;
    idx_nxt   = evt.evt_idx;
    kind_nxt  = evt.evt_kind;
    ptr_nxt   = ptr;
    if (load_c) begin
      valid_nxt = 1'b1;
      idx_nxt   = grant_c;
      kind_nxt  = q_k0[grant_c];
      ptr_nxt   = (32'(grant_c) == N - 1) ? '0 : grant_c + IDXW'(1);
    end else if (evt.evt_ready) begin
      valid_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler; event word is {valid, idx, kind}.
module tb_button_event_scheduler;
  localparam int unsigned N    = 4;
  localparam int unsigned IDXW = 2;

  logic         clk;
  logic         rst;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] overrun;
  logic         clear_overrun;

  int n_checks;
  int n_fail;

  button_event_scheduler_if #(.IDXW(IDXW)) evt();

  button_event_scheduler #(.N(N), .IDXW(IDXW)) dut (
    .clk           (clk),
    .rst           (rst),
    .rise          (rise),
    .fall          (fall),
    .evt           (evt),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ev_word();
    return {evt.evt_valid, evt.evt_idx, evt.evt_kind};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; rise = '0; fall = '0; clear_overrun = 1'b0; evt.evt_ready = 1'b0;
    step(); step();
    n_checks++;
    if (ev_word() !== 4'b0_00_0) begin
      n_fail++; $display("FAIL reset_evt: got %b, expected 0000", ev_word());
    end
    n_checks++;
    if (overrun !== 4'b0000) begin
      n_fail++; $display("FAIL reset_overrun: got %b, expected 0000", overrun);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    evt.evt_ready = 1'b1;
    rise = 4'b0100; step(); rise = '0;
    n_checks++;
    if (evt.evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_lat1: valid=%b, expected 0", evt.evt_valid);
    end
    step();
    n_checks++;
    if (ev_word() !== 4'b1_10_1) begin
      n_fail++; $display("FAIL single_press: got %b, expected 1101", ev_word());
    end
    step();
    n_checks++;
    if (evt.evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drain1: valid=%b, expected 0", evt.evt_valid);
    end
    fall = 4'b0100; step(); fall = '0;
    step();
    n_checks++;
    if (ev_word() !== 4'b1_10_0) begin
      n_fail++; $display("FAIL single_release: got %b, expected 1100", ev_word());
    end
    step();
    n_checks++;
    if (evt.evt_valid !== 1'b0 || overrun !== 4'b0000) begin
      n_fail++; $display("FAIL single_end: valid=%b overrun=%b, expected 0/0000", evt.evt_valid, overrun);
    end
  endtask

  task automatic test_rr();
    logic [3:0] exp_a [4];
    logic [3:0] exp_b [3];
    exp_a = '{4'b1_00_1, 4'b1_01_1, 4'b1_11_1, 4'b0_11_1};
    exp_b = '{4'b1_00_1, 4'b1_11_1, 4'b0_11_1};
    do_reset();
    evt.evt_ready = 1'b1;
    rise = 4'b1011; step(); rise = '0; step();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ev_word() !== exp_a[i]) begin
        n_fail++; $display("FAIL rr_013[%0d]: got %b, expected %b", i, ev_word(), exp_a[i]);
      end
      step();
    end
    rise = 4'b1001; step(); rise = '0; step();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ev_word() !== exp_b[i]) begin
        n_fail++; $display("FAIL rr_wrap[%0d]: got %b, expected %b", i, ev_word(), exp_b[i]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    evt.evt_ready = 1'b0;
    rise = 4'b0010; step(); rise = '0; step();
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (ev_word() !== 4'b1_01_1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got %b, expected 1011", c, ev_word());
      end
      fall = (c == 1) ? 4'b0010 : 4'b0000;
      if (c == 3) evt.evt_ready = 1'b1;
      step();
    end
    fall = '0;
    n_checks++;
    if (ev_word() !== 4'b1_01_0) begin
      n_fail++; $display("FAIL bp_release: got %b, expected 1010", ev_word());
    end
    step();
    n_checks++;
    if (evt.evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: valid=%b, expected 0", evt.evt_valid);
    end
  endtask

  task automatic test_overrun();
    evt.evt_ready = 1'b0;
    rise = 4'b0100; step(); rise = '0; step();
    rise = 4'b0001; step(); rise = '0;
    fall = 4'b0001; step(); fall = '0;
    rise = 4'b0001; step(); rise = '0;
    n_checks++;
    if (overrun !== 4'b0001) begin
      n_fail++; $display("FAIL ovr_set: got %b, expected 0001", overrun);
    end
    n_checks++;
    if (ev_word() !== 4'b1_10_1) begin
      n_fail++; $display("FAIL ovr_head: got %b, expected 1101", ev_word());
    end
    evt.evt_ready = 1'b1; step();
    n_checks++;
    if (ev_word() !== 4'b1_00_1) begin
      n_fail++; $display("FAIL ovr_ev1: got %b, expected 1001", ev_word());
    end
    step();
    n_checks++;
    if (ev_word() !== 4'b1_00_0) begin
      n_fail++; $display("FAIL ovr_ev2: got %b, expected 1000", ev_word());
    end
    step(); step();
    n_checks++;
    if (evt.evt_valid !== 1'b0 || overrun !== 4'b0001) begin
      n_fail++; $display("FAIL ovr_only2: valid=%b overrun=%b, expected 0/0001", evt.evt_valid, overrun);
    end
    clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
    n_checks++;
    if (overrun !== 4'b0000) begin
      n_fail++; $display("FAIL ovr_clear: got %b, expected 0000", overrun);
    end
    clear_overrun = 1'b1; rise = 4'b0001; fall = 4'b0001; step();
    clear_overrun = 1'b0; rise = '0; fall = '0;
    n_checks++;
    if (overrun !== 4'b0001) begin
      n_fail++; $display("FAIL ovr_set_wins: got %b, expected 0001", overrun);
    end
    step(); step();
    n_checks++;
    if (evt.evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovr_both_no_evt: valid=%b, expected 0", evt.evt_valid);
    end
    clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
  endtask

  task automatic test_push_pop();
    logic [3:0] exp_s [4];
    exp_s = '{4'b1_10_0, 4'b1_10_1, 4'b1_10_0, 4'b0_10_0};
    evt.evt_ready = 1'b0;
    rise = 4'b0100; step(); rise = '0; step();
    n_checks++;
    if (ev_word() !== 4'b1_10_1) begin
      n_fail++; $display("FAIL pp_first: got %b, expected 1101", ev_word());
    end
    fall = 4'b0100; step(); fall = '0;
    rise = 4'b0100; step(); rise = '0;
    evt.evt_ready = 1'b1; fall = 4'b0100; step(); fall = '0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ev_word() !== exp_s[i]) begin
        n_fail++; $display("FAIL pp_seq[%0d]: got %b, expected %b", i, ev_word(), exp_s[i]);
      end
      step();
    end
    n_checks++;
    if (overrun !== 4'b0000) begin
      n_fail++; $display("FAIL pp_no_overrun: got %b, expected 0000", overrun);
    end
    rise = 4'b0010; fall = 4'b0010; step(); rise = '0; fall = '0;
    n_checks++;
    if (overrun !== 4'b0010) begin
      n_fail++; $display("FAIL pp_both_overrun: got %b, expected 0010", overrun);
    end
    step(); step();
    n_checks++;
    if (evt.evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL pp_both_no_evt: valid=%b, expected 0", evt.evt_valid);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_r [3];
    exp_r = '{4'b1_00_1, 4'b1_11_1, 4'b0_11_1};
    evt.evt_ready = 1'b0;
    rise = 4'b0101; step(); rise = '0; step();
    n_checks++;
    if (ev_word() !== 4'b1_00_1) begin
      n_fail++; $display("FAIL ar_pre: got %b, expected 1001", ev_word());
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (evt.evt_valid !== 1'b0 || overrun !== 4'b0000) begin
      n_fail++; $display("FAIL ar_immediate: valid=%b overrun=%b, expected 0/0000", evt.evt_valid, overrun);
    end
    #2 rst = 1'b1;
    evt.evt_ready = 1'b1;
    step(); step();
    n_checks++;
    if (evt.evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL ar_queues_clear: valid=%b, expected 0", evt.evt_valid);
    end
    rise = 4'b1001; step(); rise = '0; step();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ev_word() !== exp_r[i]) begin
        n_fail++; $display("FAIL ar_after[%0d]: got %b, expected %b", i, ev_word(), exp_r[i]);
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_rr();
    test_backpressure();
    test_overrun();
    test_push_pop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event_scheduler.md
Name: button_event_scheduler

Overview:
- Collects rise/fall pulses from N debounced-button edge detectors and serializes them into a single event stream with a valid/ready handshake.
- Buffers up to two alternating edges per button, arbitrates round-robin across buttons, and flags lost events.
- Sits between the per-button debounce/edge-detect front ends and the UI/CPU-side consumer.

Parameters:
- N, 4, number of buttons (2..16).
- IDXW, 2, width of the event index; must equal ceil(log2(N)).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rise  in  N  one-cycle rise pulse per button, from its edge detector.
- fall  in  N  one-cycle fall pulse per button.
- evt_valid  out  1  output event present.
- evt_ready  in  1  consumer accepts the event when high together with evt_valid.
- evt_idx  out  IDXW  button index of the event.
- evt_kind  out  1  1 = press (rise), 0 = release (fall).
- overrun  out  N  sticky per-button lost-event flag.
- clear_overrun  in  1  one-cycle pulse; clears all overrun bits.

Behaviour:
- Reset (rst low, async): all pending state cleared; evt_valid=0, evt_idx=0, evt_kind=0, overrun=0, RR pointer=0.
- Per-button queue, 2 entries deep, FIFO ordered:
  - States: EMPTY, ONE(k), TWO(k, ~k). k is the kind of the older entry.
  - An edge on an EMPTY queue gives ONE(kind).
  - An edge on ONE(k) gives TWO(k, kind). Opposite kind is the normal case. The same kind is also accepted.
  - An edge on TWO sets overrun[i]. The new edge is dropped and the queue is unchanged.
- rise[i] and fall[i] both high in the same cycle: both ignored, overrun[i] set.
- Arbiter:
  - Candidates are buttons with a non-empty queue.
  - Grant goes to the first candidate at or after ptr, wrapping from N-1 to 0.
  - After a grant, ptr = grant+1 (mod N).
  - At most one grant per cycle.
- Output register load:
  - Occurs when (!evt_valid || evt_ready) and at least one candidate exists.
  - Load: evt_valid=1, evt_idx=grant, evt_kind=oldest entry of that queue. That entry is popped in the same cycle.
  - If no candidate and evt_ready was high: evt_valid goes to 0.
- Stability: while evt_valid && !evt_ready, evt_idx and evt_kind are held stable, and no pop occurs.
- Latency:
  - Pulse in cycle t is enqueued at the edge ending t.
  - The event is visible on evt_valid in cycle t+2 if the output is free and the button wins arbitration.
  - Full throughput: one event per cycle while evt_ready=1.
- Same-cycle pop and push on one queue:
  - The pop is applied first, then the push.
  - TWO + pop + edge gives TWO, with no overrun.
  - ONE + pop + edge gives ONE(new kind).
- overrun:
  - Sticky.
  - clear_overrun zeroes all bits.
  - A new overrun condition in the same cycle as clear_overrun leaves that bit set (set wins).
- Reset asserted mid-transfer: the pending event is discarded; there is no partial output.
- No combinational path from evt_ready to evt_valid, evt_idx or evt_kind.

Test Plan:
- Single press/release: rise[2] pulse at cycle 10, fall[2] at cycle 20, evt_ready=1.
  - Required: evt_valid in cycle 12 with idx=2, kind=1.
  - Required: evt_valid in cycle 22 with idx=2, kind=0.
  - Required: overrun=0.
- Round-robin: rise on buttons 0, 1 and 3 in the same cycle, ready=1.
  - Required: events in consecutive cycles in order idx 0, 1, 3.
  - Next: rise on 0 and 3 simultaneously. Required: idx 0 first (ptr=0 after wrap from 3), then 3.
- Backpressure: evt_ready=0; press then release on button 1, 3 cycles apart.
  - Required: evt_valid=1 with idx=1, kind=1 held stable.
  - Raise ready: required sequence kind=1 then kind=0, then evt_valid=0.
- Overrun: ready=0; rise[0], fall[0], rise[0] on separate cycles.
  - Required: overrun[0]=1.
  - Required: exactly two events delivered (rise, fall) once ready=1.
  - Then clear_overrun: required overrun=0. Clear in the same cycle as a new overrun: required bit stays 1.
- Simultaneous push/pop: button 2 queue at TWO while output handshakes; an edge on button 2 in the same cycle as its pop.
  - Required: no overrun, all 3 events delivered in order.
  - Also: rise[1] and fall[1] high together. Required: overrun[1]=1 and no event from button 1.
- Async reset: assert rst low mid-cycle with evt_valid=1 and queues non-empty.
  - Required: evt_valid, overrun and all queues clear immediately, without waiting for a clock edge.
  - After release: new pulses are handled normally, ptr starts at 0.
